// File: rtl/aer_spike_encoder.sv
// AER transmit encoder: captures one spike vector per timestep and streams the
// index of every set bit, lowest first, over a valid/ready channel.
module aer_spike_encoder #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_NEURONS-1:0] spikes_in,
  input  logic                step,
  output logic                step_ready,
  output logic                aer_valid,
  input  logic                aer_ready,
  output logic [ADDR_W-1:0]   aer_addr,
  output logic                aer_last,
  output logic                step_done,
  output logic [ADDR_W:0]     event_count,
  output logic                step_dropped
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [N_NEURONS-1:0] pending_q;
  logic [ADDR_W:0]      count_q;
  logic [ADDR_W:0]      event_count_q;
  logic                 step_dropped_q;

  logic [N_NEURONS-1:0] pending_rest;
  logic                 one_left;
  logic [ADDR_W-1:0]    lowest_idx;

  // Clearing the lowest set bit and testing for a single remaining bit both
  // reduce to pending & (pending - 1).
  always_comb begin
    pending_rest = pending_q & (pending_q - N_NEURONS'(1));
    one_left     = (pending_q != '0) && (pending_rest == '0);
  end

  always_comb begin
    lowest_idx = '0;
    for (int unsigned i = N_NEURONS; i > 0; i--) begin
      if (pending_q[i-1]) lowest_idx = ADDR_W'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pending_q      <= '0;
      count_q        <= '0;
      event_count_q  <= '0;
      step_dropped_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step) begin
            pending_q <= spikes_in;
            count_q   <= '0;
            state_q   <= (spikes_in != '0) ? S_EMIT : S_DONE;
          end
        end
        S_EMIT: begin
          if (step) step_dropped_q <= 1'b1;
          if (aer_ready) begin
            pending_q <= pending_rest;
            count_q   <= count_q + (ADDR_W + 1)'(1);
            if (one_left) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (step) step_dropped_q <= 1'b1;
          event_count_q <= count_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; aer_ready never reaches aer_valid.
  assign step_ready   = (state_q == S_IDLE);
  assign aer_valid    = (state_q == S_EMIT);
  assign aer_addr     = (state_q == S_EMIT) ? lowest_idx : '0;
  assign aer_last     = (state_q == S_EMIT) && one_left;
  assign step_done    = (state_q == S_DONE);
  assign event_count  = event_count_q;
  assign step_dropped = step_dropped_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: queue-based event model checked every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_aer_spike_encoder;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  spikes_in;
  logic          step;
  logic          step_ready;
  logic          aer_valid;
  logic          aer_ready;
  logic [AW-1:0] aer_addr;
  logic          aer_last;
  logic          step_done;
  logic [AW:0]   event_count;
  logic          step_dropped;

  int vectors   = 0;
  int miscompares = 0;

  aer_spike_encoder #(.N_NEURONS(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spikes_in   (spikes_in),
    .step        (step),
    .step_ready  (step_ready),
    .aer_valid   (aer_valid),
    .aer_ready   (aer_ready),
    .aer_addr    (aer_addr),
    .aer_last    (aer_last),
    .step_done   (step_done),
    .event_count (event_count),
    .step_dropped(step_dropped)
  );

  always #5 clk = ~clk;

  // Model: the events still owed are a queue of neuron indices; a timestep is
  // "done" for one cycle after its queue empties (or immediately if empty).
  int unsigned ev_q[$];
  bit          m_done   = 1'b0;
  int unsigned m_sent   = 0;
  int unsigned m_evcnt  = 0;
  bit          m_drop   = 1'b0;
  bit          m_known  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ev_q.delete();
      m_done  = 1'b0;
      m_sent  = 0;
      m_evcnt = 0;
      m_drop  = 1'b0;
      m_known = 1'b1;
    end else if (m_done) begin
      if (step) m_drop = 1'b1;
      m_evcnt = m_sent;
      m_done  = 1'b0;
    end else if (ev_q.size() > 0) begin
      if (step) m_drop = 1'b1;
      if (aer_ready) begin
        void'(ev_q.pop_front());
        m_sent++;
        if (ev_q.size() == 0) m_done = 1'b1;
      end
    end else if (step) begin
      m_sent = 0;
      for (int unsigned i = 0; i < N; i++)
        if (spikes_in[i]) ev_q.push_back(i);
      if (ev_q.size() == 0) m_done = 1'b1;
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int unsigned ea;
    if (!m_known) return;
    ea = (ev_q.size() > 0) ? ev_q[0] : 0;
    chk("m_aer_valid",   aer_valid,   ev_q.size() > 0);
    chk("m_aer_addr",    aer_addr,    ea);
    chk("m_aer_last",    aer_last,    ev_q.size() == 1);
    chk("m_step_done",   step_done,   m_done);
    chk("m_step_ready",  step_ready,  !m_done && ev_q.size() == 0);
    chk("m_event_count", event_count, m_evcnt);
    chk("m_step_dropped",step_dropped,m_drop);
  endtask

  // Advance one clock; inputs change only after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic start_step(input logic [N-1:0] v);
    spikes_in = v;
    step      = 1'b1;
    tick();
    step      = 1'b0;
    spikes_in = $urandom();
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; spikes_in = '0; aer_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", aer_valid, 0);
    chk("rst_addr", aer_addr, 0);
    chk("rst_last", aer_last, 0);
    chk("rst_done", step_done, 0);
    chk("rst_count", event_count, 0);
    chk("rst_dropped", step_dropped, 0);
    chk("rst_ready", step_ready, 1);
    rst_n = 1'b1;
    tick();

    // 2,5,7 with ready high
    start_step(8'b1010_0100);
    chk("t1_addr0", aer_addr, 2); chk("t1_last0", aer_last, 0); tick();
    chk("t1_addr1", aer_addr, 5); chk("t1_last1", aer_last, 0); tick();
    chk("t1_addr2", aer_addr, 7); chk("t1_last2", aer_last, 1); tick();
    chk("t1_done", step_done, 1); chk("t1_valid", aer_valid, 0); tick();
    chk("t1_ready", step_ready, 1); chk("t1_count", event_count, 3);

    // empty timestep
    start_step(8'h00);
    chk("t2_valid", aer_valid, 0); chk("t2_done", step_done, 1); tick();
    chk("t2_ready", step_ready, 1); chk("t2_count", event_count, 0);

    // back-pressure holds address 0
    aer_ready = 1'b0;
    start_step(8'b0000_0011);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", aer_valid, 1); chk("t3_hold_addr", aer_addr, 0);
      tick();
    end
    aer_ready = 1'b1;
    chk("t3_addr0", aer_addr, 0); tick();
    chk("t3_addr1", aer_addr, 1); chk("t3_last1", aer_last, 1); tick();
    chk("t3_done", step_done, 1); tick();
    chk("t3_count", event_count, 2);

    // all neurons
    start_step(8'hFF);
    for (int unsigned i = 0; i < N; i++) begin
      chk("t4_addr", aer_addr, i); chk("t4_last", aer_last, i == N - 1);
      tick();
    end
    chk("t4_done", step_done, 1); tick();
    chk("t4_count", event_count, 8);

    // reset after 2 of 3 events
    start_step(8'b0000_0111);
    tick(); tick();
    chk("t5_addr2", aer_addr, 2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_valid", aer_valid, 0); chk("t5_done", step_done, 0);
    chk("t5_count", event_count, 0); chk("t5_ready", step_ready, 1);
    tick();
    chk("t5_done_after", step_done, 0);

    // step during EMIT is dropped
    start_step(8'b0001_0010);
    chk("t6_addr0", aer_addr, 1);
    spikes_in = 8'h01; step = 1'b1; tick(); step = 1'b0;
    chk("t6_addr1", aer_addr, 4); chk("t6_last", aer_last, 1);
    chk("t6_dropped", step_dropped, 1); tick();
    chk("t6_done", step_done, 1); tick();
    chk("t6_count", event_count, 2); chk("t6_ready", step_ready, 1);
    chk("t6_valid", aer_valid, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0:       spikes_in = '0;
        1:       spikes_in = '1;
        default: spikes_in = N'($urandom());
      endcase
      step      = ($urandom_range(0, 3) == 0);
      aer_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; step = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
